// File: rtl/hcsr04_trig_gen.sv
// HC-SR04 trigger generator: issues the trigger pulse, supervises echo, enforces the measurement period.
// Optional saturating timeout counter on port err_cnt when HCSR04_TRIG_ERRCNT_EN is defined.
module hcsr04_trig_gen #(
    parameter int TRIG_US      = 10,
    parameter int ECHO_WAIT_US = 5000,
    parameter int ECHO_MAX_US  = 38000,
    parameter int PERIOD_US    = 60000,
    parameter int CW           = 20
) (
    input  logic       clk_1m,
    input  logic       rst,
    input  logic       start,
    input  logic       auto_en,
    input  logic       echo,
    output logic       trig,
    output logic       busy,
    output logic       done,
    output logic       timeout
`ifdef HCSR04_TRIG_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_HI, WAIT_LO, HOLD} state_t;

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_US - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(ECHO_WAIT_US - 1);
    localparam logic [CW-1:0] ECHO_LAST = CW'(ECHO_MAX_US - 1);
    localparam logic [CW-1:0] PER_LAST  = CW'(PERIOD_US - 1);

    state_t        state;
    logic [CW-1:0] phase_cnt;
    logic [CW-1:0] per_cnt;
    logic          s0, s1, s2;
    logic          rise, fall;

    assign rise = s1 & ~s2;
    assign fall = ~s1 & s2;
    assign busy = (state != IDLE);

    always_ff @(posedge clk_1m) begin
        if (!rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            per_cnt   <= '0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            trig      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            s0        <= echo;
            s1        <= s0;
            s2        <= s1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            phase_cnt <= phase_cnt + 1'b1;
            per_cnt   <= per_cnt + 1'b1;
            case (state)
                // Counters sit at zero in IDLE, so entering TRIG starts both from 0.
                IDLE: begin
                    phase_cnt <= '0;
                    per_cnt   <= '0;
                    if (start | auto_en) begin
                        state <= TRIG;
                        trig  <= 1'b1;
                    end
                end
                TRIG: begin
                    if (phase_cnt == TRIG_LAST) begin
                        trig      <= 1'b0;
                        state     <= WAIT_HI;
                        phase_cnt <= '0;
                    end
                end
                WAIT_HI: begin
                    if (rise) begin
                        state     <= WAIT_LO;
                        phase_cnt <= '0;
                    end else if (phase_cnt == WAIT_LAST) begin
                        timeout   <= 1'b1;
                        state     <= HOLD;
                        phase_cnt <= '0;
                    end
                end
                WAIT_LO: begin
                    if (fall) begin
                        done      <= 1'b1;
                        state     <= HOLD;
                        phase_cnt <= '0;
                    end else if (phase_cnt == ECHO_LAST) begin
                        timeout   <= 1'b1;
                        state     <= HOLD;
                        phase_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (per_cnt == PER_LAST) begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    trig      <= 1'b0;
                    phase_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HCSR04_TRIG_ERRCNT_EN
    always_ff @(posedge clk_1m) begin
        if (!rst)
            err_cnt <= '0;
        else if (timeout && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_hcsr04_trig_gen.sv
// Directed bench for hcsr04_trig_gen with short timing parameters.
// Build with HCSR04_TRIG_ERRCNT_EN to also exercise err_cnt saturation.
module tb_hcsr04_trig_gen;

    logic clk_1m = 1'b0;
    logic rst, start, auto_en, echo;
    logic trig, busy, done, timeout;
`ifdef HCSR04_TRIG_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int rel   = 0;

    hcsr04_trig_gen #(
        .TRIG_US(10), .ECHO_WAIT_US(50), .ECHO_MAX_US(100), .PERIOD_US(300), .CW(20)
    ) dut (
        .clk_1m(clk_1m), .rst(rst), .start(start), .auto_en(auto_en), .echo(echo),
        .trig(trig), .busy(busy), .done(done), .timeout(timeout)
`ifdef HCSR04_TRIG_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk_1m = ~clk_1m;

    task automatic tick();
        @(posedge clk_1m);
        #1;
        rel++;
    endtask

    task automatic go(input int k);
        while (rel < k) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at rel=%0d: observed=%0h expected=%0h", tag, rel, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic t, input logic b, input logic d, input logic to);
        chk({tag, ".trig"}, 32'(trig), 32'(t));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    // Start a measurement: rel 0 is the cycle start is raised, trig is high from rel 1.
    task automatic kick();
        start = 1'b1;
        rel = 0;
        go(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; auto_en = 1'b0; echo = 1'b0;
        repeat (3) tick();
        chk_out("reset", 0, 0, 0, 0);
`ifdef HCSR04_TRIG_ERRCNT_EN
        chk("reset.err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b1;
        repeat (3) tick();
        chk_out("idle", 0, 0, 0, 0);

        // Normal cycle: echo high from rel 20 to rel 80
        kick();
        chk_out("t1.trig_on", 1, 1, 0, 0);
        go(10); chk("t1.trig_last", 32'(trig), 32'd1);
        go(11); chk_out("t1.trig_off", 0, 1, 0, 0);
        go(20); echo = 1'b1;
        go(80); echo = 1'b0;
        go(82); chk("t1.done_early", 32'(done), 32'd0);
        go(83); chk_out("t1.done", 0, 1, 1, 0);
        go(84); chk("t1.done_len", 32'(done), 32'd0);
        go(300); chk("t1.busy_hold", 32'(busy), 32'd1);
        go(301); chk_out("t1.idle", 0, 0, 0, 0);
        go(305);

        // No echo at all
        kick();
        go(60); chk("t2.to_early", 32'(timeout), 32'd0);
        go(61); chk_out("t2.timeout", 0, 1, 0, 1);
        go(62); chk("t2.to_len", 32'(timeout), 32'd0);
        go(300); chk("t2.busy_hold", 32'(busy), 32'd1);
        go(301); chk_out("t2.idle", 0, 0, 0, 0);
        go(305);

        // Echo too long: WAIT_LO entered at rel 23, limit reached at rel 123
        kick();
        go(20); echo = 1'b1;
        go(122); chk("t3a.to_early", 32'(timeout), 32'd0);
        go(123); chk_out("t3a.timeout", 0, 1, 0, 1);
        go(200); echo = 1'b0;
        go(205); chk("t3a.late_fall_ignored", 32'(done), 32'd0);
        go(301); chk_out("t3a.idle", 0, 0, 0, 0);

        // Echo stuck high before start: no rise, times out in WAIT_HI
        echo = 1'b1;
        go(310);
        kick();
        go(60); chk("t3b.to_early", 32'(timeout), 32'd0);
        go(61); chk_out("t3b.timeout", 0, 1, 0, 1);
        go(100); echo = 1'b0;
        go(301); chk_out("t3b.idle", 0, 0, 0, 0);
        go(305);

        // Auto mode, echo width 40, stray start pulses while busy
        auto_en = 1'b1;
        rel = 0;
        for (int i = 0; i < 5; i++) begin
            int base;
            base = 1 + 301 * i;
            go(base); chk("t4.trig_rise", 32'(trig), 32'd1);
            go(base + 19); echo = 1'b1;
            go(base + 59); echo = 1'b0;
            go(base + 62); chk_out("t4.done", 0, 1, 1, 0);
            go(base + 100); start = 1'b1;
            go(base + 101); start = 1'b0;
            go(base + 299); chk_out("t4.hold_end", 0, 1, 0, 0);
            go(base + 300); chk_out("t4.idle_gap", 0, 0, 0, 0);
        end
        auto_en = 1'b0;
        go(1507); chk_out("t4.stopped", 0, 0, 0, 0);

        // Reset in the middle of the trigger pulse
        kick();
        go(5); chk("t5.trig_mid", 32'(trig), 32'd1);
        rst = 1'b0;
        go(6); chk_out("t5.reset", 0, 0, 0, 0);
        rst = 1'b1;
        go(8);
        kick();
        go(10); chk_out("t5.trig_last", 1, 1, 0, 0);
        go(11); chk_out("t5.trig_off", 0, 1, 0, 0);
        go(301); chk("t5.idle", 32'(busy), 32'd0);
        go(305);

        // Rise lands exactly on the last WAIT_HI cycle: rise wins
        kick();
        go(58); echo = 1'b1;
        go(61); chk_out("t6.edge_rise", 0, 1, 0, 0);
        go(70); echo = 1'b0;
        go(73); chk_out("t6.edge_done", 0, 1, 1, 0);
        go(301); chk("t6.idle", 32'(busy), 32'd0);
        go(305);

        // One cycle later is too late: timeout
        kick();
        go(59); echo = 1'b1;
        go(61); chk_out("t6.late_timeout", 0, 1, 0, 1);
        go(100); echo = 1'b0;
        go(301); chk("t6.late_idle", 32'(busy), 32'd0);
        go(305);

`ifdef HCSR04_TRIG_ERRCNT_EN
        chk("ec.after_reset", 32'(err_cnt), 32'd1);
        echo = 1'b0;
        auto_en = 1'b1;
        rel = 0;
        go(259 * 301 + 100); auto_en = 1'b0;
        go(260 * 301 + 2);
        chk("ec.idle", 32'(busy), 32'd0);
        chk("ec.saturate", 32'(err_cnt), 32'd255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
